// File: rtl/rv32f_sequencer_if.sv
// Decode-to-sequencer handshake and sequencer-to-datapath strobes.
// master: decode/driver side; slave: the sequencer itself.
interface rv32f_sequencer_if;
  logic        iVALID;
  logic [31:0] iIR;
  logic        oREADY;
  logic        oSTALL;
  logic [31:0] oIR;
  logic        oRAM_CE;
  logic        oRAM_RD;
  logic        oRAM_WR;
  logic        oFRF_WE;
  logic        oXRF_WE;
  logic        oDONE;
  logic        oILLEGAL;

  modport master (
    output iVALID, iIR,
    input  oREADY, oSTALL, oIR,
    input  oRAM_CE, oRAM_RD, oRAM_WR,
    input  oFRF_WE, oXRF_WE,
    input  oDONE, oILLEGAL
  );

  modport slave (
    input  iVALID, iIR,
    output oREADY, oSTALL, oIR,
    output oRAM_CE, oRAM_RD, oRAM_WR,
    output oFRF_WE, oXRF_WE,
    output oDONE, oILLEGAL
  );
endinterface

// File: rtl/rv32f_sequencer.sv
// RV32F multi-cycle issue controller: classifies, sequences, stalls.
// Ports: iCLK, iRST (sync, high), bus = rv32f_sequencer_if.slave.
module rv32f_sequencer #(
  parameter int ADD_LAT  = 2,
  parameter int MUL_LAT  = 3,
  parameter int FMA_LAT  = 4,
  parameter int DIV_LAT  = 12,
  parameter int SQRT_LAT = 16,
  parameter int MEM_LAT  = 1
) (
  input  logic iCLK,
  input  logic iRST,
  rv32f_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE, EXEC, MEM, WB
  } state_t;

  localparam logic [4:0] CADD  = 5'(ADD_LAT - 1);
  localparam logic [4:0] CMUL  = 5'(MUL_LAT - 1);
  localparam logic [4:0] CFMA  = 5'(FMA_LAT - 1);
  localparam logic [4:0] CDIV  = 5'(DIV_LAT - 1);
  localparam logic [4:0] CSQRT = 5'(SQRT_LAT - 1);
  localparam logic [4:0] CMEM  = 5'(MEM_LAT - 1);

  state_t     state;
  logic [4:0] cnt;
  logic       wbF;
  logic       wbX;
  logic       ready;
  logic       accept;

  logic [6:0] opc;
  logic [6:0] f7;
  logic [4:0] rs2;
  logic [2:0] rm;

  logic       dLegal;
  logic       dMem;
  logic       dStore;
  logic       dF;
  logic       dX;
  logic [4:0] dCnt;

  assign opc = bus.iIR[6:0];
  assign rm  = bus.iIR[14:12];
  assign rs2 = bus.iIR[24:20];
  assign f7  = bus.iIR[31:25];

  always_comb begin
    dLegal = 1'b0;
    dMem   = 1'b0;
    dStore = 1'b0;
    dF     = 1'b0;
    dX     = 1'b0;
    dCnt   = 5'd0;
    unique case (1'b1)
      (opc == 7'b0000111): begin
        dLegal = 1'b1;
        dMem   = 1'b1;
        dF     = 1'b1;
        dCnt   = CMEM;
      end
      (opc == 7'b0100111): begin
        dLegal = 1'b1;
        dMem   = 1'b1;
        dStore = 1'b1;
        dCnt   = CMEM;
      end
      (opc == 7'b1000011),
      (opc == 7'b1000111),
      (opc == 7'b1001011),
      (opc == 7'b1001111): begin
        dLegal = 1'b1;
        dF     = 1'b1;
        dCnt   = CFMA;
      end
      (opc == 7'b1010011): begin
        unique case (f7)
          7'b0000000,
          7'b0000100: begin
            dLegal = 1'b1;
            dCnt   = CADD;
          end
          7'b0001000: begin
            dLegal = 1'b1;
            dCnt   = CMUL;
          end
          7'b0001100: begin
            dLegal = 1'b1;
            dCnt   = CDIV;
          end
          7'b0101100: begin
            dLegal = (rs2 == 5'd0);
            dCnt   = CSQRT;
          end
          7'b0010100: dLegal = (rm <= 3'd1);
          7'b0010000: dLegal = (rm <= 3'd2);
          7'b1101000: dLegal = (rs2 <= 5'd1);
          7'b1111000:
            dLegal = (rs2 == 5'd0) && (rm == 3'd0);
          7'b1100000: begin
            dLegal = (rs2 <= 5'd1);
            dX     = 1'b1;
          end
          7'b1110000: begin
            dLegal = (rm <= 3'd1);
            dX     = 1'b1;
          end
          7'b1010000: begin
            dLegal = (rm <= 3'd2);
            dX     = 1'b1;
          end
          default: dLegal = 1'b0;
        endcase
        dF = ~dX;
      end
      default: dLegal = 1'b0;
    endcase
  end

  assign ready = ~iRST & ((state == IDLE) | (state == WB));
  assign accept = bus.iVALID & ready;
  assign bus.oREADY = ready;
  assign bus.oSTALL = bus.iVALID & ~ready;

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state        <= IDLE;
      cnt          <= 5'd0;
      wbF          <= 1'b0;
      wbX          <= 1'b0;
      bus.oIR      <= 32'd0;
      bus.oRAM_CE  <= 1'b0;
      bus.oRAM_RD  <= 1'b0;
      bus.oRAM_WR  <= 1'b0;
      bus.oFRF_WE  <= 1'b0;
      bus.oXRF_WE  <= 1'b0;
      bus.oDONE    <= 1'b0;
      bus.oILLEGAL <= 1'b0;
    end else begin
      bus.oRAM_WR  <= 1'b0;
      bus.oFRF_WE  <= 1'b0;
      bus.oXRF_WE  <= 1'b0;
      bus.oDONE    <= 1'b0;
      bus.oILLEGAL <= 1'b0;
      unique case (state)
        EXEC: begin
          if (cnt == 5'd0) begin
            state       <= WB;
            bus.oDONE   <= 1'b1;
            bus.oFRF_WE <= wbF;
            bus.oXRF_WE <= wbX;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        MEM: begin
          if (cnt == 5'd0) begin
            state       <= WB;
            bus.oDONE   <= 1'b1;
            bus.oFRF_WE <= wbF;
            bus.oRAM_CE <= 1'b0;
            bus.oRAM_RD <= 1'b0;
          end else begin
            cnt <= cnt - 5'd1;
          end
        end
        default: begin
          // IDLE and WB both accept; WB chains straight into the next op.
          if (accept) begin
            bus.oIR <= bus.iIR;
            wbF     <= dF;
            wbX     <= dX;
            cnt     <= dCnt;
            if (!dLegal) begin
              state        <= IDLE;
              bus.oILLEGAL <= 1'b1;
              wbF          <= 1'b0;
              wbX          <= 1'b0;
            end else if (dMem) begin
              state       <= MEM;
              bus.oRAM_CE <= 1'b1;
              bus.oRAM_RD <= ~dStore;
              bus.oRAM_WR <= dStore;
            end else begin
              state <= EXEC;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32f_sequencer.sv
// Directed vector bench for rv32f_sequencer.
// Table of single ops plus back-to-back and reset corner sequences.
module tb_rv32f_sequencer;

  logic iCLK;
  logic iRST;
  int   nChecks;
  int   nFail;

  rv32f_sequencer_if bus();

  rv32f_sequencer dut (
    .iCLK (iCLK),
    .iRST (iRST),
    .bus  (bus)
  );

  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  typedef struct {
    string       name;
    logic [31:0] ir;
    int          lat;
    bit          ill;
    bit          mem;
    bit          st;
    bit          wf;
    bit          wx;
  } vec_t;

  vec_t vecs[17];

  localparam logic [31:0] FADD = 32'h003100D3;
  localparam logic [31:0] FDIV = 32'h183100D3;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  task automatic quiet(input string nm);
    chk({nm, " done"}, 32'(bus.oDONE), 0);
    chk({nm, " fwe"}, 32'(bus.oFRF_WE), 0);
    chk({nm, " xwe"}, 32'(bus.oXRF_WE), 0);
  endtask

  task automatic runVec(input vec_t v);
    @(negedge iCLK);
    chk({v.name, " rdy0"}, 32'(bus.oREADY), 1);
    bus.iVALID = 1'b1;
    bus.iIR    = v.ir;
    @(negedge iCLK);
    bus.iVALID = 1'b0;
    bus.iIR    = 32'hDEADBEEF;
    chk({v.name, " oIR"}, bus.oIR, v.ir);
    if (v.ill) begin
      chk({v.name, " ill"}, 32'(bus.oILLEGAL), 1);
      chk({v.name, " irdy"}, 32'(bus.oREADY), 1);
      chk({v.name, " ice"}, 32'(bus.oRAM_CE), 0);
      quiet(v.name);
      @(negedge iCLK);
      chk({v.name, " ill1"}, 32'(bus.oILLEGAL), 0);
      quiet(v.name);
    end else begin
      chk({v.name, " ill"}, 32'(bus.oILLEGAL), 0);
      for (int k = 1; k <= v.lat; k++) begin
        if (k > 1) @(negedge iCLK);
        chk({v.name, " busy"}, 32'(bus.oREADY), 0);
        chk({v.name, " ce"}, 32'(bus.oRAM_CE),
            32'(v.mem));
        chk({v.name, " rd"}, 32'(bus.oRAM_RD),
            32'(v.mem & ~v.st));
        chk({v.name, " wr"}, 32'(bus.oRAM_WR),
            32'(v.st && k == 1));
        quiet(v.name);
      end
      @(negedge iCLK);
      chk({v.name, " wbdone"}, 32'(bus.oDONE), 1);
      chk({v.name, " wbf"}, 32'(bus.oFRF_WE),
          32'(v.wf));
      chk({v.name, " wbx"}, 32'(bus.oXRF_WE),
          32'(v.wx));
      chk({v.name, " wbce"}, 32'(bus.oRAM_CE), 0);
      chk({v.name, " wbwr"}, 32'(bus.oRAM_WR), 0);
      chk({v.name, " wbrdy"}, 32'(bus.oREADY), 1);
      @(negedge iCLK);
      quiet(v.name);
    end
  endtask

  initial begin
    nChecks    = 0;
    nFail      = 0;
    iRST       = 1'b1;
    bus.iVALID = 1'b0;
    bus.iIR    = 32'd0;

    vecs[0]  = '{"fadd",  FADD,         2, 0,0,0,1,0};
    vecs[1]  = '{"fsub",  32'h083100D3, 2, 0,0,0,1,0};
    vecs[2]  = '{"fmul",  32'h103100D3, 3, 0,0,0,1,0};
    vecs[3]  = '{"fdiv",  FDIV,        12, 0,0,0,1,0};
    vecs[4]  = '{"fsqrt", 32'h580000D3,16, 0,0,0,1,0};
    vecs[5]  = '{"fmadd", 32'h00310043, 4, 0,0,0,1,0};
    vecs[6]  = '{"fnmadd",32'h0031004F, 4, 0,0,0,1,0};
    vecs[7]  = '{"flw",   32'h0000A087, 1, 0,1,0,1,0};
    vecs[8]  = '{"fsw",   32'h0020A027, 1, 0,1,1,0,0};
    vecs[9]  = '{"feq",   32'hA02120D3, 1, 0,0,0,0,1};
    vecs[10] = '{"fmin",  32'h283100D3, 1, 0,0,0,1,0};
    vecs[11] = '{"fcvtw", 32'hC00000D3, 1, 0,0,0,0,1};
    vecs[12] = '{"fmvwx", 32'hF00000D3, 1, 0,0,0,1,0};
    vecs[13] = '{"bad7",  32'hFE0000D3, 0, 1,0,0,0,0};
    vecs[14] = '{"sqrt1", 32'h581000D3, 0, 1,0,0,0,0};
    vecs[15] = '{"sgnj3", 32'h203130D3, 0, 1,0,0,0,0};
    vecs[16] = '{"intop", 32'h00000033, 0, 1,0,0,0,0};

    repeat (2) @(negedge iCLK);
    chk("rst rdy", 32'(bus.oREADY), 0);
    chk("rst oIR", bus.oIR, 0);
    chk("rst ce", 32'(bus.oRAM_CE), 0);
    chk("rst ill", 32'(bus.oILLEGAL), 0);
    quiet("rst");
    iRST = 1'b0;
    #1;
    chk("rel rdy", 32'(bus.oREADY), 1);

    foreach (vecs[i]) runVec(vecs[i]);

    // FDIV with FADD queued behind it on a held iVALID.
    @(negedge iCLK);
    bus.iVALID = 1'b1;
    bus.iIR    = FDIV;
    @(negedge iCLK);
    bus.iIR = FADD;
    for (int k = 1; k <= 12; k++) begin
      chk("b2b stall", 32'(bus.oSTALL), 1);
      chk("b2b oIR", bus.oIR, FDIV);
      quiet("b2b");
      @(negedge iCLK);
    end
    chk("b2b wbf", 32'(bus.oFRF_WE), 1);
    chk("b2b wbd", 32'(bus.oDONE), 1);
    chk("b2b nost", 32'(bus.oSTALL), 0);
    @(negedge iCLK);
    bus.iVALID = 1'b0;
    chk("b2b oIR2", bus.oIR, FADD);
    quiet("b2b2");
    @(negedge iCLK);
    quiet("b2b2");
    @(negedge iCLK);
    chk("b2b2 wbf", 32'(bus.oFRF_WE), 1);
    chk("b2b2 wbd", 32'(bus.oDONE), 1);

    // Reset at T+5 of an FDIV discards it.
    @(negedge iCLK);
    bus.iVALID = 1'b1;
    bus.iIR    = FDIV;
    @(negedge iCLK);
    bus.iVALID = 1'b0;
    repeat (4) @(negedge iCLK);
    iRST = 1'b1;
    #1;
    chk("mrst rdy", 32'(bus.oREADY), 0);
    @(negedge iCLK);
    chk("mrst oIR", bus.oIR, 0);
    quiet("mrst");
    iRST = 1'b0;
    #1;
    chk("mrst rdy1", 32'(bus.oREADY), 1);
    for (int k = 0; k < 14; k++) begin
      @(negedge iCLK);
      quiet("mrst");
      chk("mrst idle", 32'(bus.oREADY), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
